bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Multi-digit synchronous BCD up/down counter. It is the source stage that generates the BCD digit stream consumed by the bcd_to_2421 converter, one 4-bit digit per converter instance. It supports parallel load, count enable, direction control and a registered wrap pulse for cascading.

Parameters:
DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant in bits [3:0].

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable, sampled on rising edge
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  parallel load strobe, sampled on rising edge
load_val  input  4*DIGITS  value to load, digit i in bits [4i+3:4i]
bcd  output  4*DIGITS  registered count, every nibble always 0..9
wrap  output  1  registered one-cycle pulse on full-range wrap
tc  output  1  combinational terminal count: all digits 9 when up=1, all digits 0 when up=0
load_err  output  1  registered one-cycle error pulse (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): bcd=0, wrap=0, load_err=0 immediately. No clock is needed for reset to take effect.
- Priority each edge: load > en > hold.
- load=1:
  - bcd takes load_val, with legality rules as defined under Optional Feature.
  - wrap=0. en and up are ignored this cycle.
- load=0, en=1, up=1:
  - Digit 0 increments.
  - Digit i increments only when all lower digits equal 9; a digit at 9 that increments becomes 0.
  - At all-9s the next value is all-0s and wrap=1 for exactly that cycle.
- load=0, en=1, up=0:
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits equal 0; a digit at 0 that decrements becomes 9.
  - At all-0s the next value is all-9s and wrap=1 for that cycle.
- load=0, en=0: bcd holds, wrap=0.
- Latency: bcd and wrap change one clock after the sampled control.
- tc is combinational from bcd and up, so en & tc predicts wrap on the next edge (for cascading).
- Direction change while counting takes effect on the same edge; there is no pipeline.
- Reset asserted mid-count: reset wins instantly, and counting resumes from 0 on the first edge after deassertion.
- Invariant: no bcd nibble ever holds 10..15.
- load_err is 0 whenever load=0 on the previous edge.

Optional Feature:
Macro BCD_LOAD_CHECK_EN.
- Defined:
  - On load, if any nibble of load_val exceeds 9, the whole load is rejected.
  - bcd holds its previous value and load_err pulses 1 for one cycle.
  - A legal load gives load_err=0.
- Not defined:
  - load_err is tied to 0.
  - Each illegal nibble (10..15) is loaded as 0 and legal nibbles load normally.
  - Either way, the no-illegal-nibble invariant holds.

Test Plan:
- Reset: rst_n=0 asserted between clock edges, with bcd at 0x57 -> bcd=0x00, wrap=0 without any clock edge.
- Up count: DIGITS=2, reset, en=1, up=1 for 100 cycles -> bcd goes 00,01,..,09,10,..,99,00; wrap=1 only on the 99->00 cycle; tc=1 while bcd=99.
- Down count: load 0x01, then en=1, up=0 -> bcd 01,00,99,98; wrap=1 only on the 00->99 cycle.
- Priority and hold: bcd=0x42, load=1 with load_val=0x17 and en=1 -> bcd=0x17. Then en=0 for 5 cycles -> bcd stays 0x17, wrap=0.
- Illegal load, load_val=0x3C:
  - With BCD_LOAD_CHECK_EN: bcd unchanged, load_err=1 for one cycle.
  - Without it: bcd=0x30, load_err=0.
- Checker integration: feed each bcd nibble to a bcd_to_2421 instance across a full up sweep -> every converter input is 0..9 on every cycle and the 2421 outputs match the reference table.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load and a registered wrap pulse for cascading.
// Define BCD_LOAD_CHECK_EN to reject loads containing a nibble above 9 and flag them on load_err.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap,
  output logic                  tc,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] step;
  logic                wrap_q, wrap_d;
  logic                all9, all0;
  logic                carry;

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      all9 &= (bcd_q[4*i +: 4] == 4'd9);
      all0 &= (bcd_q[4*i +: 4] == 4'd0);
    end
  end

  assign tc = up ? all9 : all0;

  // Ripple carry/borrow: a digit moves only when every lower digit is at its terminal value.
  always_comb begin
    step  = bcd_q;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (up) begin
          step[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : bcd_q[4*i +: 4] + 4'd1;
        end else begin
          step[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd0) ? 4'd9 : bcd_q[4*i +: 4] - 4'd1;
        end
      end
      carry = carry & (up ? (bcd_q[4*i +: 4] == 4'd9) : (bcd_q[4*i +: 4] == 4'd0));
    end
  end

`ifdef BCD_LOAD_CHECK_EN
  logic lv_bad;
  logic err_q, err_d;

  always_comb begin
    lv_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) lv_bad = 1'b1;
    end
  end

  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (lv_bad) err_d = 1'b1;
      else        bcd_d = load_val;
    end else if (en) begin
      bcd_d  = step;
      wrap_d = tc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign load_err = err_q;
`else
  logic [4*DIGITS-1:0] lv_clean;

  // Illegal nibbles are squashed to 0 so the count never leaves BCD.
  always_comb begin
    lv_clean = load_val;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) lv_clean[4*i +: 4] = 4'd0;
    end
  end

  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (load) begin
      bcd_d = lv_clean;
    end else if (en) begin
      bcd_d  = step;
      wrap_d = tc;
    end
  end

  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised self-checking bench for bcd_updown_counter; the reference model counts as an integer.
module tb_bcd_updown_counter;

  localparam int DIGITS = 2;
  localparam int MAXV   = 10**DIGITS - 1;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic                up;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd;
  logic                wrap;
  logic                tc;
  logic                load_err;

  int n_pass;
  int n_total;

  // Reference model state: the count as a plain integer.
  int mv;
  bit mw;
  bit merr;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .wrap     (wrap),
    .tc       (tc),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit exp_tc(input int v, input logic u);
    return u ? (v == MAXV) : (v == 0);
  endfunction

  function automatic bit nibbles_legal(input logic [4*DIGITS-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Drives one cycle of inputs, advances the model at the edge, leaves time at edge+1.
  task automatic tick(input logic ld, input logic [4*DIGITS-1:0] lv, input logic e,
                      input logic u);
    int  sum;
    int  w;
    bit  bad;
    load     = ld;
    load_val = lv;
    en       = e;
    up       = u;
    @(posedge clk);
    merr = 1'b0;
    mw   = 1'b0;
    if (ld) begin
      bad = 1'b0;
      sum = 0;
      w   = 1;
      for (int i = 0; i < DIGITS; i++) begin
        if (lv[4*i +: 4] > 4'd9) bad = 1'b1;
        else sum += int'(lv[4*i +: 4]) * w;
        w *= 10;
      end
`ifdef BCD_LOAD_CHECK_EN
      if (bad) merr = 1'b1;
      else     mv   = sum;
`else
      mv = sum;
`endif
    end else if (e) begin
      if (u) begin
        mw = (mv == MAXV);
        mv = (mv + 1) % (MAXV + 1);
      end else begin
        mw = (mv == 0);
        mv = (mv + MAXV) % (MAXV + 1);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    #12;
    n_total++;
    if (bcd !== '0 || wrap !== 1'b0 || load_err !== 1'b0)
      $display("FAIL reset_initial bcd=%h wrap=%b err=%b want 00/0/0", bcd, wrap, load_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    mv = 0;
    tick(1'b1, 8'h57, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    n_total++;
    if (bcd !== 8'h57) $display("FAIL reset_preload bcd=%h want 57", bcd);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bcd !== 8'h00 || wrap !== 1'b0 || load_err !== 1'b0)
      $display("FAIL reset_async bcd=%h wrap=%b err=%b want 00/0/0", bcd, wrap, load_err);
    else n_pass++;
    mv = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_up_sweep();
    for (int c = 0; c <= MAXV + 1; c++) begin
      n_total++;
      if (tc !== exp_tc(mv, 1'b1)) $display("FAIL up_tc bcd=%h tc=%b want %b", bcd, tc,
                                            exp_tc(mv, 1'b1));
      else n_pass++;
      tick(1'b0, 8'h00, 1'b1, 1'b1);
      n_total++;
      if (bcd !== to_bcd(mv) || wrap !== mw || !nibbles_legal(bcd))
        $display("FAIL up_sweep cyc=%0d bcd=%h wrap=%b want %h/%b", c, bcd, wrap,
                 to_bcd(mv), mw);
      else n_pass++;
    end
    n_total++;
    if (bcd !== 8'h01) $display("FAIL up_sweep_end bcd=%h want 01", bcd);
    else n_pass++;
  endtask

  task automatic test_down();
    logic [7:0] seq [4];
    bit         wexp [4];
    seq[0] = 8'h00; seq[1] = 8'h99; seq[2] = 8'h98; seq[3] = 8'h97;
    wexp[0] = 1'b0; wexp[1] = 1'b1; wexp[2] = 1'b0; wexp[3] = 1'b0;
    tick(1'b1, 8'h01, 1'b1, 1'b0);
    n_total++;
    if (bcd !== 8'h01 || wrap !== 1'b0) $display("FAIL down_load bcd=%h wrap=%b want 01/0",
                                                bcd, wrap);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      n_total++;
      if (bcd !== seq[k] || wrap !== wexp[k] || bcd !== to_bcd(mv) || wrap !== mw)
        $display("FAIL down_step%0d bcd=%h wrap=%b want %h/%b", k, bcd, wrap, seq[k], wexp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_priority_hold();
    tick(1'b1, 8'h42, 1'b0, 1'b1);
    tick(1'b1, 8'h17, 1'b1, 1'b1);
    n_total++;
    if (bcd !== 8'h17 || wrap !== 1'b0) $display("FAIL load_priority bcd=%h wrap=%b want 17/0",
                                                bcd, wrap);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 8'h00, 1'b0, k[0]);
      n_total++;
      if (bcd !== 8'h17 || wrap !== 1'b0 || load_err !== 1'b0)
        $display("FAIL hold%0d bcd=%h wrap=%b err=%b want 17/0/0", k, bcd, wrap, load_err);
      else n_pass++;
    end
  endtask

  task automatic test_illegal_load();
    tick(1'b1, 8'h3C, 1'b1, 1'b1);
`ifdef BCD_LOAD_CHECK_EN
    n_total++;
    if (bcd !== 8'h17 || load_err !== 1'b1)
      $display("FAIL illegal_load bcd=%h err=%b want 17/1", bcd, load_err);
    else n_pass++;
`else
    n_total++;
    if (bcd !== 8'h30 || load_err !== 1'b0)
      $display("FAIL illegal_load bcd=%h err=%b want 30/0", bcd, load_err);
    else n_pass++;
`endif
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    n_total++;
    if (load_err !== 1'b0 || bcd !== to_bcd(mv))
      $display("FAIL illegal_load_after bcd=%h err=%b want %h/0", bcd, load_err, to_bcd(mv));
    else n_pass++;
  endtask

  task automatic test_reset_midcount();
    tick(1'b1, 8'h45, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bcd !== 8'h00 || wrap !== 1'b0) $display("FAIL reset_mid bcd=%h wrap=%b want 00/0",
                                                bcd, wrap);
    else n_pass++;
    mv = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    n_total++;
    if (bcd !== 8'h01) $display("FAIL reset_resume bcd=%h want 01", bcd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       ld;
    logic [7:0] lv;
    for (int c = 0; c < 400; c++) begin
      ld = ($urandom_range(0, 7) == 0);
      lv = 8'($urandom);
      if (ld && $urandom_range(0, 1) == 1) lv = to_bcd(int'($urandom_range(0, MAXV)));
      // Occasionally steer near the wrap points so both terminal counts are hit often.
      if (ld && $urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00;
      tick(ld, lv, 1'($urandom_range(0, 3) != 0), 1'($urandom));
      n_total++;
      if (bcd !== to_bcd(mv) || wrap !== mw || load_err !== merr || tc !== exp_tc(mv, up))
        $display("FAIL random cyc=%0d bcd=%h wrap=%b err=%b tc=%b want %h/%b/%b/%b", c, bcd,
                 wrap, load_err, tc, to_bcd(mv), mw, merr, exp_tc(mv, up));
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    mv      = 0;
    mw      = 1'b0;
    merr    = 1'b0;
    test_reset();
    test_up_sweep();
    test_down();
    test_priority_hold();
    test_illegal_load();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
